// File: rtl/cfg_arb_pkg.sv
// ----------------------------------------------------------------------------
// cfg_arb_pkg
// Shared types and constants for the configuration write arbiter.
//   arb_state_t : port-ownership FSM states (IDLE / OWNED)
//   ARB_FIXED   : ARB_MODE value for fixed priority (source 0 highest)
//   ARB_RR      : ARB_MODE value for round-robin
//   wrap_inc()  : modulo-n increment used for the round-robin pointer
// ----------------------------------------------------------------------------
package cfg_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/config_src_fifo.sv
// ----------------------------------------------------------------------------
// config_src_fifo
// Per-source word buffer with show-ahead read (rdata is the head word).
//   clk    : rising-edge clock
//   reset  : synchronous active-high, flushes the buffer
//   push   : write wdata (ignored when full)
//   wdata  : word to buffer
//   pop    : advance past the head word (ignored when empty)
//   rdata  : head word, valid while empty=0
//   full   : FIFO_DEPTH words held
//   empty  : no words held
// FIFO_DEPTH must be a power of two >= 2.
// ----------------------------------------------------------------------------
module config_src_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/config_write_arbiter.sv
// ----------------------------------------------------------------------------
// config_write_arbiter
// Merges NUM_SRC configuration write streams onto one port. Every source
// buffers its words locally; one source at a time owns the port and drains
// its buffer, one word per cycle, until it drops src_active with an empty
// buffer.
//   CLK               : rising-edge clock
//   reset             : synchronous active-high reset
//   src_data          : per-source words, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_strobe        : per-source one-cycle write pulse
//   src_active        : per-source ownership request (mid-bitstream)
//   src_full          : per-source buffer full
//   src_overflow      : per-source sticky "word dropped" flag
//   ovf_count         : per-source saturating dropped-word count, 8 bits each
//                       (present only with CFG_ARB_OVF_COUNT_EN defined)
//   ConfigWriteData   : merged word, holds when strobe is low
//   ConfigWriteStrobe : one-cycle valid for ConfigWriteData
//   ConfigOwner       : owning source index, 0 when idle
//   ConfigBusy        : a source owns the port
// Optional feature macro: CFG_ARB_OVF_COUNT_EN
// ----------------------------------------------------------------------------
module config_write_arbiter
    import cfg_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ARB_MODE   = ARB_FIXED
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]            src_strobe,
    input  logic [NUM_SRC-1:0]            src_active,
    output logic [NUM_SRC-1:0]            src_full,
    output logic [NUM_SRC-1:0]            src_overflow,
`ifdef CFG_ARB_OVF_COUNT_EN
    output logic [NUM_SRC*8-1:0]          ovf_count,
`endif
    output logic [DATA_WIDTH-1:0]         ConfigWriteData,
    output logic                          ConfigWriteStrobe,
    output logic [$clog2(NUM_SRC)-1:0]    ConfigOwner,
    output logic                          ConfigBusy
);

    localparam int OW = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]    fifo_empty;
    logic [NUM_SRC-1:0]    fifo_full;
    logic [NUM_SRC-1:0]    fifo_push;
    logic [NUM_SRC-1:0]    fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_rdata [NUM_SRC];
    logic [NUM_SRC-1:0]    drop;
    logic [NUM_SRC-1:0]    cand;

    arb_state_t            state;
    logic [OW-1:0]         owner;
    logic [OW-1:0]         rr_ptr;
    logic [OW-1:0]         grant_idx;
    logic [OW-1:0]         scan_idx;
    logic                  grant_valid;

    // Fullness is judged before any same-cycle pop, so a strobe into a full
    // buffer is always dropped.
    assign fifo_push   = src_strobe & ~fifo_full;
    assign drop        = src_strobe & fifo_full;
    assign src_full    = fifo_full;
    assign ConfigOwner = owner;
    assign ConfigBusy  = (state == ST_OWNED);

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        config_src_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (CLK),
            .reset (reset),
            .push  (fifo_push[g]),
            .wdata (src_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .pop   (fifo_pop[g]),
            .rdata (fifo_rdata[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g])
        );
    end

    always_comb begin
        fifo_pop = '0;
        if (state == ST_OWNED) fifo_pop[owner] = ~fifo_empty[owner];
    end

    // Candidate scan: fixed priority starts at 0, round-robin starts at the
    // slot after the last released owner; first candidate found wins.
    always_comb begin
        cand        = src_active | ~fifo_empty;
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (ARB_MODE == ARB_RR) scan_idx = OW'((32'(rr_ptr) + k) % NUM_SRC);
            else                    scan_idx = OW'(k);
            if (!grant_valid && cand[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state             <= ST_IDLE;
            owner             <= '0;
            rr_ptr            <= '0;
            ConfigWriteData   <= '0;
            ConfigWriteStrobe <= 1'b0;
        end else begin
            ConfigWriteStrobe <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        state <= ST_OWNED;
                        owner <= grant_idx;
                    end
                end
                ST_OWNED: begin
                    if (!fifo_empty[owner]) begin
                        ConfigWriteStrobe <= 1'b1;
                        ConfigWriteData   <= fifo_rdata[owner];
                    end else if (!src_active[owner]) begin
                        state  <= ST_IDLE;
                        owner  <= '0;
                        rr_ptr <= OW'(wrap_inc(32'(owner), NUM_SRC));
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) src_overflow <= '0;
        else       src_overflow <= src_overflow | drop;
    end

`ifdef CFG_ARB_OVF_COUNT_EN
    always_ff @(posedge CLK) begin
        if (reset) begin
            ovf_count <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (drop[i] && (ovf_count[i*8 +: 8] != 8'hFF))
                    ovf_count[i*8 +: 8] <= ovf_count[i*8 +: 8] + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_config_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_config_write_arbiter
// Two arbiters (fixed priority and round-robin) share one directed stimulus.
// A queue-based model predicts every output each cycle; emitted words are
// also logged and pinned against hand-computed sequences.
// Optional feature macro: CFG_ARB_OVF_COUNT_EN
// ----------------------------------------------------------------------------
module tb_config_write_arbiter;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic            reset;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]    src_strobe;
    logic [N-1:0]    src_active;

    logic [N-1:0]    a_full [2];
    logic [N-1:0]    a_ovf  [2];
    logic [DW-1:0]   a_data [2];
    logic            a_stb  [2];
    logic [1:0]      a_own  [2];
    logic            a_busy [2];
`ifdef CFG_ARB_OVF_COUNT_EN
    logic [N*8-1:0]  a_ovfc [2];
`endif

    config_write_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ARB_MODE(0)) dut_fix (
        .CLK(CLK), .reset(reset), .src_data(src_data), .src_strobe(src_strobe),
        .src_active(src_active), .src_full(a_full[0]), .src_overflow(a_ovf[0]),
`ifdef CFG_ARB_OVF_COUNT_EN
        .ovf_count(a_ovfc[0]),
`endif
        .ConfigWriteData(a_data[0]), .ConfigWriteStrobe(a_stb[0]),
        .ConfigOwner(a_own[0]), .ConfigBusy(a_busy[0])
    );

    config_write_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ARB_MODE(1)) dut_rr (
        .CLK(CLK), .reset(reset), .src_data(src_data), .src_strobe(src_strobe),
        .src_active(src_active), .src_full(a_full[1]), .src_overflow(a_ovf[1]),
`ifdef CFG_ARB_OVF_COUNT_EN
        .ovf_count(a_ovfc[1]),
`endif
        .ConfigWriteData(a_data[1]), .ConfigWriteStrobe(a_stb[1]),
        .ConfigOwner(a_own[1]), .ConfigBusy(a_busy[1])
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // ---------------- behavioural model (index 0 = fixed, 1 = round-robin)
    logic [DW-1:0] mq [2][N][$];
    int            m_own [2];
    int            m_rr  [2];
    logic          m_stb [2];
    logic [DW-1:0] m_data[2];
    logic [N-1:0]  m_ovf [2];
    int            m_cnt [2][N];

    function automatic void model_reset(input int d);
        for (int i = 0; i < N; i++) begin
            mq[d][i].delete();
            m_cnt[d][i] = 0;
        end
        m_own[d]  = -1;
        m_rr[d]   = 0;
        m_stb[d]  = 1'b0;
        m_data[d] = '0;
        m_ovf[d]  = '0;
    endfunction

    function automatic void model_step(input int d);
        bit was_full [N];
        if (reset) begin
            model_reset(d);
            return;
        end
        for (int i = 0; i < N; i++) was_full[i] = (mq[d][i].size() == DEPTH);
        m_stb[d] = 1'b0;
        if (m_own[d] >= 0) begin
            if (mq[d][m_own[d]].size() > 0) begin
                m_data[d] = mq[d][m_own[d]].pop_front();
                m_stb[d]  = 1'b1;
            end else if (!src_active[m_own[d]]) begin
                m_rr[d]  = (m_own[d] + 1) % N;
                m_own[d] = -1;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (d == 1) ? (m_rr[d] + k) % N : k;
                if (m_own[d] < 0 && (src_active[i] || mq[d][i].size() > 0)) m_own[d] = i;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (src_strobe[i]) begin
                if (was_full[i]) begin
                    m_ovf[d][i] = 1'b1;
                    if (m_cnt[d][i] < 255) m_cnt[d][i]++;
                end else begin
                    mq[d][i].push_back(src_data[i*DW +: DW]);
                end
            end
        end
    endfunction

    // ---------------- emitted-word log
    typedef struct packed {
        int          cyc;
        int          own;
        logic [31:0] data;
    } ent_t;

    ent_t logq [2][$];
    ent_t expq [$];

    always @(posedge CLK) begin
        cyc++;
        for (int d = 0; d < 2; d++) model_step(d);
        #1;
        for (int d = 0; d < 2; d++) begin
            logic [75:0] act;
            logic [75:0] exp;
            logic [31:0] e_ovfc;
            logic [31:0] x_ovfc;
            logic [N-1:0] e_full;
            logic [1:0]  e_own;
            for (int i = 0; i < N; i++) begin
                e_full[i]          = (mq[d][i].size() == DEPTH);
                e_ovfc[i*8 +: 8]   = 8'(m_cnt[d][i]);
            end
            e_own = (m_own[d] < 0) ? 2'd0 : m_own[d][1:0];
`ifdef CFG_ARB_OVF_COUNT_EN
            x_ovfc = a_ovfc[d];
`else
            x_ovfc = '0;
            e_ovfc = '0;
`endif
            act = {a_stb[d], a_data[d], a_own[d], a_busy[d], a_full[d], a_ovf[d], x_ovfc};
            exp = {m_stb[d], m_data[d], e_own, (m_own[d] >= 0), e_full, m_ovf[d], e_ovfc};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL cycle_cmp dut=%0d cyc=%0d act stb=%b data=%h own=%0d busy=%b full=%b ovf=%b ovfc=%h req stb=%b data=%h own=%0d busy=%b full=%b ovf=%b ovfc=%h",
                         d, cyc, a_stb[d], a_data[d], a_own[d], a_busy[d], a_full[d], a_ovf[d], x_ovfc,
                         m_stb[d], m_data[d], e_own, (m_own[d] >= 0), e_full, m_ovf[d], e_ovfc);
            end
            if (a_stb[d]) logq[d].push_back('{cyc: cyc, own: int'(a_own[d]), data: a_data[d]});
        end
    end

    // ---------------- helpers
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h req=%0h", name, act, exp);
        end
    endtask

    task automatic chk_log(input int d, input string name, input int first_cyc);
        chk({name, "_count"}, 64'(logq[d].size()), 64'(expq.size()));
        for (int k = 0; k < expq.size(); k++) begin
            if (k < logq[d].size()) begin
                chk({name, "_own"},  64'(logq[d][k].own),  64'(expq[k].own));
                chk({name, "_data"}, 64'(logq[d][k].data), 64'(expq[k].data));
                if (first_cyc >= 0) chk({name, "_cyc"}, 64'(logq[d][k].cyc), 64'(first_cyc + k));
            end
        end
    endtask

    task automatic add_exp(input int own, input logic [31:0] data);
        expq.push_back('{cyc: 0, own: own, data: data});
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_word(input int i, input logic [31:0] w);
        src_data[i*DW +: DW] = w;
    endtask

    task automatic clear_logs();
        logq[0].delete();
        logq[1].delete();
        expq.delete();
    endtask

    // ---------------- directed stimulus
    initial begin
        int s;
        for (int d = 0; d < 2; d++) model_reset(d);
        reset      = 1'b1;
        src_data   = '0;
        src_strobe = '0;
        src_active = '0;
        step(2);
        reset = 1'b0;
        step(1);
        chk("rst_busy", 64'(a_busy[0]), 64'd0);
        chk("rst_data", 64'(a_data[0]), 64'd0);

        // Source 2 owns, four back-to-back words appear one edge after each push.
        clear_logs();
        src_active = 4'b0100;
        step(2);
        s = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            set_word(2, 32'hA5A5_0001 + 32'(k));
            src_strobe = 4'b0100;
            step(1);
        end
        src_strobe = '0;
        step(4);
        src_active = '0;
        step(4);
        for (int k = 0; k < 4; k++) add_exp(2, 32'hA5A5_0001 + 32'(k));
        chk_log(0, "s1_fix", s + 1);
        chk_log(1, "s1_rr",  s + 1);

        // Sources 1 and 3 request together.
        clear_logs();
        src_active = 4'b1010;
        step(1);
        for (int k = 0; k < 3; k++) begin
            set_word(3, 32'hC300_0001 + 32'(k));
            set_word(1, 32'hC100_0001);
            src_strobe = (k == 0) ? 4'b1010 : 4'b1000;
            step(1);
        end
        src_strobe = '0;
        step(4);
        src_active = 4'b1000;
        step(8);
        src_active = '0;
        step(8);
        add_exp(1, 32'hC100_0001);
        for (int k = 0; k < 3; k++) add_exp(3, 32'hC300_0001 + 32'(k));
        chk_log(0, "s2_fix", -1);
        expq.delete();
        for (int k = 0; k < 3; k++) add_exp(3, 32'hC300_0001 + 32'(k));
        add_exp(1, 32'hC100_0001);
        chk_log(1, "s2_rr", -1);

        // Non-owner source 1 overfills its buffer while source 0 owns.
        clear_logs();
        src_active = 4'b0001;
        step(2);
        for (int k = 0; k < 6; k++) begin
            set_word(1, 32'hD100_0001 + 32'(k));
            src_strobe = 4'b0010;
            step(1);
        end
        src_strobe = '0;
        chk("s3_full", 64'(a_full[0][1]), 64'd1);
        chk("s3_ovf",  64'(a_ovf[0][1]),  64'd1);
        chk("s3_model_cnt", 64'(m_cnt[0][1]), 64'd2);
`ifdef CFG_ARB_OVF_COUNT_EN
        chk("s3_ovf_count", 64'(a_ovfc[0][15:8]), 64'd2);
`endif
        step(1);
        src_active = '0;
        step(10);
        chk("s3_full_drained", 64'(a_full[0][1]), 64'd0);
        chk("s3_ovf_sticky",   64'(a_ovf[0][1]),  64'd1);
        for (int k = 0; k < 4; k++) add_exp(1, 32'hD100_0001 + 32'(k));
        chk_log(0, "s3_fix", -1);
        chk_log(1, "s3_rr",  -1);

        // Owner 3 stays active without data while source 0 requests.
        src_active = 4'b1000;
        step(2);
        clear_logs();
        src_active = 4'b1001;
        step(10);
        chk("s4_fix_nostb", 64'(logq[0].size()), 64'd0);
        chk("s4_rr_nostb",  64'(logq[1].size()), 64'd0);
        chk("s4_fix_own",   64'(a_own[0]), 64'd3);
        chk("s4_rr_own",    64'(a_own[1]), 64'd3);
        chk("s4_model_own", 64'(m_own[0]), 64'd3);
        src_active = 4'b0001;
        step(4);
        chk("s4_fix_own0",  64'(a_own[0]),  64'd0);
        chk("s4_fix_busy0", 64'(a_busy[0]), 64'd1);
        src_active = '0;
        step(4);

        // Reset with three words buffered; next bitstream starts clean.
        src_active = 4'b0001;
        step(2);
        for (int k = 0; k < 3; k++) begin
            set_word(1, 32'h9999_0001 + 32'(k));
            src_strobe = 4'b0010;
            step(1);
        end
        src_strobe = '0;
        step(1);
        clear_logs();
        reset      = 1'b1;
        src_active = 4'b0010;
        set_word(1, 32'h7777_7777);
        src_strobe = 4'b0010;
        step(2);
        reset      = 1'b0;
        src_strobe = '0;
        src_active = '0;
        step(1);
        chk("s5_nostb",  64'(logq[0].size()), 64'd0);
        chk("s5_data0",  64'(a_data[0]), 64'd0);
        chk("s5_own0",   64'(a_own[0]),  64'd0);
        chk("s5_busy0",  64'(a_busy[0]), 64'd0);
        chk("s5_full0",  64'(a_full[0]), 64'd0);
        chk("s5_ovf0",   64'(a_ovf[0]),  64'd0);
        src_active = 4'b0010;
        step(2);
        for (int k = 0; k < 2; k++) begin
            set_word(1, 32'hF100_0001 + 32'(k));
            src_strobe = 4'b0010;
            step(1);
        end
        src_strobe = '0;
        step(4);
        src_active = '0;
        step(4);
        add_exp(1, 32'hF100_0001);
        add_exp(1, 32'hF100_0002);
        chk_log(0, "s5_fix", -1);
        chk_log(1, "s5_rr",  -1);

        // All sources request from reset; source 0 requests again later.
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        clear_logs();
        for (int i = 0; i < N; i++) set_word(i, 32'hE000_0000 + 32'(i));
        src_strobe = 4'b1111;
        step(1);
        src_strobe = '0;
        step(4);
        set_word(0, 32'hE000_0010);
        src_strobe = 4'b0001;
        step(1);
        src_strobe = '0;
        step(18);
        add_exp(0, 32'hE000_0000);
        add_exp(1, 32'hE000_0001);
        add_exp(0, 32'hE000_0010);
        add_exp(2, 32'hE000_0002);
        add_exp(3, 32'hE000_0003);
        chk_log(0, "s6_fix", -1);
        expq.delete();
        add_exp(0, 32'hE000_0000);
        add_exp(1, 32'hE000_0001);
        add_exp(2, 32'hE000_0002);
        add_exp(3, 32'hE000_0003);
        add_exp(0, 32'hE000_0010);
        chk_log(1, "s6_rr", -1);
        chk("s6_model_rr", 64'(m_rr[1]), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/config_write_arbiter.md
CONFIG_WRITE_ARBITER -- requirements
Module: config_write_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, giving the number of configuration write sources (2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the configuration word width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, giving per-source buffer depth (power of two, >=2).
REQ-004 The block SHALL have parameter ARB_MODE, default 0, selecting arbitration: 0 = fixed priority (source 0 highest), 1 = round-robin.
REQ-005 The block SHALL have port CLK  input  1  the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 The block SHALL have port src_data  input  NUM_SRC*DATA_WIDTH  per-source word; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port src_strobe  input  NUM_SRC  one-cycle write pulse per word.
REQ-009 The block SHALL have port src_active  input  NUM_SRC  source is mid-bitstream and requests port ownership.
REQ-010 The block SHALL have port src_full  output  NUM_SRC  source FIFO full.
REQ-011 The block SHALL have port src_overflow  output  NUM_SRC  sticky flag: a word was dropped.
REQ-012 The block SHALL have port ConfigWriteData  output  DATA_WIDTH  merged word to the frame logic.
REQ-013 The block SHALL have port ConfigWriteStrobe  output  1  one-cycle valid for ConfigWriteData.
REQ-014 The block SHALL have port ConfigOwner  output  clog2(NUM_SRC)  index of the owning source; 0 when idle.
REQ-015 The block SHALL have port ConfigBusy  output  1  high while any source owns the port.

Function
REQ-016 A word SHALL be pushed when src_strobe[i]=1 and src_full[i]=0; when src_full[i]=1 the word SHALL be dropped and src_overflow[i] set, even if a pop occurs in the same cycle.
REQ-017 Every source SHALL buffer words regardless of ownership.
REQ-018 The FSM SHALL have states IDLE and OWNED.
REQ-019 In IDLE, a source SHALL be a candidate when src_active[i]=1 or its FIFO is non-empty; with candidates present, the FSM SHALL grant one source (per ARB_MODE) and enter OWNED on the next edge.
REQ-020 In round-robin mode, the search SHALL start at the index after the last released owner, wrapping from NUM_SRC-1 to 0; after reset the pointer SHALL be 0.
REQ-021 In OWNED, one word per cycle SHALL be popped from the owner's FIFO when non-empty, and ConfigWriteData/ConfigWriteStrobe SHALL be registered outputs.
REQ-022 Latency: a word strobed in cycle t into an empty FIFO of an already-granted owner SHALL appear on ConfigWriteStrobe in cycle t+2.
REQ-023 Back-to-back strobes from the owner SHALL produce back-to-back ConfigWriteStrobe with no bubbles and in order.
REQ-024 The FSM SHALL return to IDLE when the owner's src_active=0 and its FIFO is empty; no other source SHALL be granted while the owner's src_active=1, even with an empty FIFO.
REQ-025 ConfigWriteStrobe SHALL be 0 in IDLE; ConfigWriteData SHALL hold its last value when the strobe is 0.
REQ-026 src_overflow[i] SHALL clear only on reset.

Reset
REQ-027 On reset=1 at a clock edge, all FIFOs SHALL be flushed, FSM=IDLE, RR pointer=0, ConfigWriteStrobe=0, ConfigWriteData=0, ConfigOwner=0, ConfigBusy=0, src_full=0, src_overflow=0.
REQ-028 A reset mid-bitstream SHALL discard buffered words without emitting them; strobes during reset SHALL be ignored.

Configuration
REQ-029 With macro CFG_ARB_OVF_COUNT_EN defined, output ovf_count (NUM_SRC*8) SHALL provide a per-source dropped-word counter that saturates at 255 and resets to 0; without it, the port and counters SHALL be absent and src_overflow SHALL be unchanged.

Structure
REQ-030 Package cfg_arb_pkg SHALL hold the FSM state type and constants ARB_FIXED=0, ARB_RR=1.
REQ-031 The per-source buffer SHALL be sub-module config_src_fifo (parameters DATA_WIDTH, FIFO_DEPTH; push, pop, full, empty), instantiated NUM_SRC times.

Verification
REQ-032 Source 2 active, strobes 0xA5A50001..0xA5A50004 in consecutive cycles -> four consecutive strobes from cycle t+2, ConfigOwner=2, in order.
REQ-033 ARB_MODE=0: sources 1 and 3 go active in the same cycle -> owner 1; after 1 releases with empty FIFO, owner 3 takes over and 3's buffered words are emitted.
REQ-034 ARB_MODE=1: all four sources repeatedly request -> grant order 0,1,2,3,0.
REQ-035 FIFO_DEPTH=4, non-owner source 1 strobes 6 words -> first 4 are emitted after grant, src_overflow[1]=1, and ovf_count=2 with CFG_ARB_OVF_COUNT_EN.
REQ-036 Reset asserted mid-stream with 3 words buffered -> no further strobe, all outputs zero, next bitstream starts cleanly.
REQ-037 Owner holds src_active=1 with no data for 10 cycles while source 0 requests -> no strobe and no owner change until release.
